lcl_mem_responder: RTL

- Responder (slave) end of the local burst read/write channel interface driven by the memcpy/action engines.
- Accepts write bursts (start/addr/num, data beats, done) and read bursts (start/addr/num, rden, returns dv/dout/done).
- Backed by an internal dual-port word RAM.
- Used as on-chip local memory and as the synthesizable memory target in engine testbenches.

---
 rtl/lcl_mem_responder.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/lcl_mem_responder.sv
// Responder end of the local burst read/write channel: independent write and read
// burst FSMs in front of a dual-port word RAM (one write port, one registered read port).
module lcl_mem_responder #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 512,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  throttle,
    input  logic                  lcl_istart,
    input  logic [ADDR_WIDTH-1:0] lcl_iaddr,
    input  logic [7:0]            lcl_inum,
    output logic                  lcl_ibusy,
    output logic                  lcl_irdy,
    input  logic                  lcl_den,
    input  logic [DATA_WIDTH-1:0] lcl_din,
    input  logic                  lcl_idone,
    input  logic                  lcl_ostart,
    input  logic [ADDR_WIDTH-1:0] lcl_oaddr,
    input  logic [7:0]            lcl_onum,
    output logic                  lcl_obusy,
    output logic                  lcl_ordy,
    input  logic                  lcl_rden,
    output logic                  lcl_dv,
    output logic [DATA_WIDTH-1:0] lcl_dout,
    output logic                  lcl_odone,
    output logic                  err
);

    localparam int BL    = $clog2(DATA_WIDTH / 8);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_DATA, R_DRAIN} rstate_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    wstate_t               w_state, w_state_d;
    logic [DEPTH_LOG2-1:0] w_idx, w_idx_d;
    logic [8:0]            w_rem, w_rem_d;
    logic                  ibusy_d, irdy_d, w_beat, w_we, w_err;

    rstate_t               r_state, r_state_d;
    logic [DEPTH_LOG2-1:0] r_idx, r_idx_d;
    logic [8:0]            r_rem, r_rem_d;
    logic                  obusy_d, ordy_d, r_req, r_err;

    // Address bits outside the word index are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{lcl_iaddr, lcl_oaddr};

    // ---------------- write channel ----------------
    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        w_state_d = w_state;
        w_idx_d   = w_idx;
        w_rem_d   = w_rem;
        ibusy_d   = lcl_ibusy;
        irdy_d    = lcl_irdy;
        w_we      = 1'b0;
        w_beat    = (w_state == W_DATA) && lcl_den && (w_rem != 9'd0);
        w_err     = (lcl_den && !w_beat) || (lcl_istart && lcl_ibusy);
        unique case (w_state)
            W_IDLE: begin
                if (lcl_istart) begin
                    w_state_d = W_DATA;
                    w_idx_d   = lcl_iaddr[BL+DEPTH_LOG2-1:BL];
                    w_rem_d   = {lcl_inum == 8'd0, lcl_inum};
                    ibusy_d   = 1'b1;
                    irdy_d    = !throttle;
                end
            end
            W_DATA: begin
                if (w_beat) begin
                    w_we    = 1'b1;
                    w_idx_d = w_idx + DEPTH_LOG2'(1);
                    w_rem_d = w_rem - 9'd1;
                end
                irdy_d = (w_rem_d != 9'd0) && !throttle;
                if (lcl_idone) begin
                    // idone together with the last beat is a clean finish; earlier is an abort.
                    w_state_d = W_IDLE;
                    ibusy_d   = 1'b0;
                    irdy_d    = 1'b0;
                    if (w_rem_d != 9'd0) begin
                        w_err   = 1'b1;
                        w_rem_d = 9'd0;
                    end
                end else if (w_beat && (w_rem_d == 9'd0)) begin
                    w_state_d = W_WAIT;
                end
            end
            W_WAIT: begin
                if (lcl_idone) begin
                    w_state_d = W_IDLE;
                    ibusy_d   = 1'b0;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // NOTE: sequential state always uses non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state   <= W_IDLE;
            w_idx     <= '0;
            w_rem     <= '0;
            lcl_ibusy <= 1'b0;
            lcl_irdy  <= 1'b0;
        end else begin
            w_state   <= w_state_d;
            w_idx     <= w_idx_d;
            w_rem     <= w_rem_d;
            lcl_ibusy <= ibusy_d;
            lcl_irdy  <= irdy_d;
        end
    end

    // NOTE: the RAM array has no reset; only control state does.
    always_ff @(posedge clk) begin
        if (w_we) mem[w_idx] <= lcl_din;
    end

    // ---------------- read channel ----------------
    always_comb begin
        r_state_d = r_state;
        r_idx_d   = r_idx;
        r_rem_d   = r_rem;
        obusy_d   = lcl_obusy;
        ordy_d    = lcl_ordy;
        r_req     = (r_state == R_DATA) && lcl_rden && (r_rem != 9'd0);
        r_err     = lcl_ostart && lcl_obusy;
        unique case (r_state)
            R_IDLE: begin
                if (lcl_ostart) begin
                    r_state_d = R_DATA;
                    r_idx_d   = lcl_oaddr[BL+DEPTH_LOG2-1:BL];
                    r_rem_d   = {lcl_onum == 8'd0, lcl_onum};
                    obusy_d   = 1'b1;
                    ordy_d    = !throttle;
                end
            end
            R_DATA: begin
                if (r_req) begin
                    r_idx_d = r_idx + DEPTH_LOG2'(1);
                    r_rem_d = r_rem - 9'd1;
                end
                ordy_d = (r_rem_d != 9'd0) && !throttle;
                if (r_rem_d == 9'd0) r_state_d = R_DRAIN;
            end
            R_DRAIN: begin
                r_state_d = R_IDLE;
                obusy_d   = 1'b0;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // The read data register samples the RAM before this edge's write lands (read-first).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= R_IDLE;
            r_idx     <= '0;
            r_rem     <= '0;
            lcl_obusy <= 1'b0;
            lcl_ordy  <= 1'b0;
            lcl_dv    <= 1'b0;
            lcl_odone <= 1'b0;
            lcl_dout  <= '0;
            err       <= 1'b0;
        end else begin
            r_state   <= r_state_d;
            r_idx     <= r_idx_d;
            r_rem     <= r_rem_d;
            lcl_obusy <= obusy_d;
            lcl_ordy  <= ordy_d;
            lcl_dv    <= r_req;
            lcl_odone <= r_req && (r_rem == 9'd1);
            if (r_req) lcl_dout <= mem[r_idx];
            err       <= err | w_err | r_err;
        end
    end

endmodule
